// File: rtl/virtual_tm1638_scanned_display.sv
// rtl/virtual_tm1638_scanned_display.sv - scanned-segment TM1638 panel renderer into a 2-stage VGA pixel pipeline
// Optional feature macro: VIRTUAL_TM1638_PERSIST_EN (per-digit refresh persistence / blanking)
module virtual_tm1638_scanned_display #(
  parameter int w_digit        = 8,
  parameter int w_led          = 8,
  parameter int w_keys         = 8,
  parameter int screen_width   = 640,
  parameter int screen_height  = 480,
  parameter int w_x            = $clog2(screen_width),
  parameter int w_y            = $clog2(screen_height),
  parameter int scale_shift    = 4,
  parameter int offset_x       = 16,
  parameter int offset_y       = 16,
  parameter int persist_frames = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         hgfedcba,
  input  logic [w_digit-1:0] digit,
  input  logic [w_led-1:0]   ledr,
  input  logic [w_keys-1:0]  keys,
  input  logic               display_on,
  input  logic               frame_start,
  input  logic [w_x-1:0]     x,
  input  logic [w_y-1:0]     y,
  output logic               red,
  output logic               green,
  output logic               blue
);

  localparam int dispx = 4 * w_digit + 1;

  // Latched segment patterns, one byte per digit (bit0 = a ... bit7 = h)
  logic [7:0] hex [w_digit];

  // Digits whose segments must be suppressed because they went stale
  logic [w_digit-1:0] stale;

  // LED/key vectors widened to one bit per digit; missing positions read as off
  logic [w_digit-1:0] led_ext;
  logic [w_digit-1:0] key_ext;

  assign led_ext = w_digit'(ledr);
  assign key_ext = w_digit'(keys);

  // Segment latch: every strobed digit captures the bus, several at once if needed
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < w_digit; i++) hex[i] <= 8'h00;
    end else begin
      for (int i = 0; i < w_digit; i++) begin
        if (digit[i]) hex[i] <= hgfedcba;
      end
    end
  end

`ifdef VIRTUAL_TM1638_PERSIST_EN
  localparam logic [7:0] age_max = 8'(persist_frames);

  // Age in frames since each digit was last strobed; saturates at age_max
  logic [7:0] age [w_digit];

  // Age counters: a strobe restarts the count and beats a coincident frame_start
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < w_digit; i++) age[i] <= age_max;
    end else begin
      for (int i = 0; i < w_digit; i++) begin
        if (digit[i]) begin
          age[i] <= 8'h00;
        end else if (frame_start && (age[i] < age_max)) begin
          age[i] <= age[i] + 8'h01;
        end
      end
    end
  end

  // A digit that reached the age limit is treated as not being driven any more
  always_comb begin
    stale = '0;
    for (int i = 0; i < w_digit; i++) stale[i] = (age[i] == age_max);
  end
`else
  // Without persistence frames are irrelevant; keep the input visibly consumed
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign stale = '0;
`endif

  // Stage 1 combinational: element coordinates and grid membership
  logic [w_x-1:0] x_rel;
  logic [w_x-1:0] ex_c;
  logic [w_y-1:0] y_rel;
  logic [w_y-1:0] ey_c;
  logic           in_c;

  assign x_rel = x - w_x'(offset_x);
  assign y_rel = y - w_y'(offset_y);
  assign ex_c  = x_rel >> scale_shift;
  assign ey_c  = y_rel >> scale_shift;
  // x/y below the origin wrap in x_rel/y_rel, so the raw compares are required too
  assign in_c  = (x >= w_x'(offset_x)) && (y >= w_y'(offset_y)) &&
                 (int'(ex_c) < dispx) && (int'(ey_c) < 8);

  logic [w_x-1:0] ex_q;
  logic [w_y-1:0] ey_q;
  logic           in_q;

  // Stage 1 register: element coordinates and in-grid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      ey_q <= '0;
      in_q <= 1'b0;
    end else begin
      ex_q <= ex_c;
      ey_q <= ey_c;
      in_q <= in_c;
    end
  end

  // Stage 2 combinational: decide which element is lit and its colour
  logic       led_lit;
  logic       key_lit;
  logic       seg_lit;
  logic       sep_lit;
  logic [2:0] rgb_c;

  // Element lookup against the current hex/LED/key state
  always_comb begin
    int col;
    int row;
    int b;
    logic [7:0] hx;
    logic       in3;
    led_lit = 1'b0;
    key_lit = 1'b0;
    seg_lit = 1'b0;
    col     = int'(ex_q);
    row     = int'(ey_q);
    b       = 0;
    hx      = 8'h00;
    in3     = 1'b0;
    sep_lit = (col >= 1) && (col <= dispx - 2);
    for (int i = 0; i < w_digit; i++) begin
      b   = (w_digit - 1 - i) * 4;
      hx  = stale[i] ? 8'h00 : hex[i];
      in3 = (col >= b + 1) && (col <= b + 3);
      if (led_ext[i] && in3) led_lit = 1'b1;
      if (key_ext[i] && in3) key_lit = 1'b1;
      case (row)
        3: if ((col == b + 2) && hx[0]) seg_lit = 1'b1;
        4: if (((col == b + 1) && hx[5]) || ((col == b + 3) && hx[1])) seg_lit = 1'b1;
        5: if ((col == b + 2) && hx[6]) seg_lit = 1'b1;
        6: if (((col == b + 1) && hx[4]) || ((col == b + 3) && hx[2])) seg_lit = 1'b1;
        7: if (((col == b + 2) && hx[3]) || ((col == b + 4) && hx[7])) seg_lit = 1'b1;
        default: ;
      endcase
    end
    case (row)
      0:       rgb_c = led_lit ? 3'b100 : 3'b000;
      1:       rgb_c = sep_lit ? 3'b111 : 3'b000;
      2:       rgb_c = key_lit ? 3'b101 : 3'b000;
      default: rgb_c = seg_lit ? 3'b111 : 3'b000;
    endcase
    if (!in_q || !display_on) rgb_c = 3'b000;
  end

  // Stage 2 register: colour outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      red   <= rgb_c[2];
      green <= rgb_c[1];
      blue  <= rgb_c[0];
    end
  end

endmodule

// File: tb/tb_virtual_tm1638_scanned_display.sv
// tb/tb_virtual_tm1638_scanned_display.sv - directed self-checking bench for virtual_tm1638_scanned_display
module tb_virtual_tm1638_scanned_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hgfedcba = 8'h00;
  logic [7:0] digit = 8'h00;
  logic [7:0] ledr = 8'h00;
  logic [7:0] keys = 8'h00;
  logic       display_on = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic       red, green, blue;

  int total = 0;
  int bad = 0;

  virtual_tm1638_scanned_display dut (
    .clk(clk), .rst(rst), .hgfedcba(hgfedcba), .digit(digit), .ledr(ledr),
    .keys(keys), .display_on(display_on), .frame_start(frame_start),
    .x(x), .y(y), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rgb();
    return {red, green, blue};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_el(input int ex, input int ey);
    x = 10'(16 + ex * 16);
    y = 9'(16 + ey * 16);
  endtask

  task automatic strobe(input logic [7:0] d, input logic [7:0] seg);
    digit = d;
    hgfedcba = seg;
    cyc(1);
    digit = 8'h00;
  endtask

  task automatic test_reset();
    logic any_lit;
    rst = 1'b1;
    cyc(2);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL reset_out got=%b want=000", rgb());
    end
    any_lit = 1'b0;
    for (int yy = 0; yy < 480; yy += 16) begin
      for (int xx = 0; xx < 640; xx += 8) begin
        x = 10'(xx);
        y = 9'(yy);
        cyc(1);
        if (rgb() !== 3'b000) any_lit = 1'b1;
      end
    end
    total++;
    if (any_lit !== 1'b0) begin
      bad++;
      $display("FAIL reset_scan got=lit want=black");
    end
    rst = 1'b0;
    set_el(31, 4);
    cyc(2);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL reset_digit0_blank got=%b want=000", rgb());
    end
  endtask

  task automatic test_digits();
    int         ex_t [6] = '{3, 2, 31, 31, 29, 27};
    int         ey_t [6] = '{4, 3, 4, 6, 4, 4};
    logic [2:0] ex_rgb [6] = '{3'b111, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000};
    strobe(8'h81, 8'h06);
    for (int k = 0; k < 6; k++) begin
      set_el(ex_t[k], ey_t[k]);
      cyc(2);
      total++;
      if (rgb() !== ex_rgb[k]) begin
        bad++;
        $display("FAIL digits_e%0d_%0d got=%b want=%b", ex_t[k], ey_t[k], rgb(), ex_rgb[k]);
      end
    end
  endtask

  task automatic test_led_keys_sep();
    int         ex_t [6] = '{1, 30, 29, 1, 0, 32};
    int         ey_t [6] = '{0, 2, 0, 1, 1, 1};
    logic [2:0] ex_rgb [6] = '{3'b100, 3'b101, 3'b000, 3'b111, 3'b000, 3'b000};
    ledr = 8'h80;
    keys = 8'h01;
    for (int k = 0; k < 6; k++) begin
      set_el(ex_t[k], ey_t[k]);
      cyc(2);
      total++;
      if (rgb() !== ex_rgb[k]) begin
        bad++;
        $display("FAIL lk_e%0d_%0d got=%b want=%b", ex_t[k], ey_t[k], rgb(), ex_rgb[k]);
      end
    end
    ledr = 8'h00;
    set_el(1, 0);
    cyc(2);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL led_off got=%b want=000", rgb());
    end
    keys = 8'h00;
  endtask

  task automatic test_latency();
    ledr = 8'h80;
    set_el(0, 0);
    cyc(3);
    set_el(1, 0);
    cyc(1);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL latency_n1 got=%b want=000", rgb());
    end
    cyc(1);
    total++;
    if (rgb() !== 3'b100) begin
      bad++;
      $display("FAIL latency_n2 got=%b want=100", rgb());
    end
    ledr = 8'h00;
    set_el(31, 4);
    cyc(3);
    digit = 8'h01;
    hgfedcba = 8'h00;
    cyc(1);
    digit = 8'h00;
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL seg_write_n1 got=%b want=111", rgb());
    end
    cyc(1);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL seg_write_n2 got=%b want=000", rgb());
    end
  endtask

  task automatic test_bounds();
    logic any_lit;
    strobe(8'hFF, 8'hFF);
    ledr = 8'hFF;
    keys = 8'hFF;
    x = 10'd15; y = 9'(16 + 4 * 16);
    cyc(2);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL bound_x_low got=%b want=000", rgb());
    end
    set_el(33, 4);
    cyc(2);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL bound_ex_dispx got=%b want=000", rgb());
    end
    set_el(31, 8);
    cyc(2);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL bound_ey8 got=%b want=000", rgb());
    end
    x = 10'd543; y = 9'(16 + 7 * 16 + 15);
    cyc(2);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL bound_last_h got=%b want=111", rgb());
    end
    display_on = 1'b0;
    any_lit = 1'b0;
    for (int ey = 0; ey < 8; ey++) begin
      for (int ex = 0; ex < 33; ex++) begin
        set_el(ex, ey);
        cyc(1);
        if (rgb() !== 3'b000) any_lit = 1'b1;
      end
    end
    total++;
    if (any_lit !== 1'b0) begin
      bad++;
      $display("FAIL display_off_scan got=lit want=black");
    end
    display_on = 1'b1;
    set_el(32, 7);
    cyc(2);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL display_on_retained got=%b want=111", rgb());
    end
    ledr = 8'h00;
    keys = 8'h00;
  endtask

  task automatic pulse_frame(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      cyc(1);
      frame_start = 1'b0;
      cyc(1);
    end
  endtask

  task automatic test_persist();
    strobe(8'h04, 8'h01);
    set_el(22, 3);
    cyc(2);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL persist_fresh got=%b want=111", rgb());
    end
    pulse_frame(2);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL persist_2frames got=%b want=111", rgb());
    end
`ifdef VIRTUAL_TM1638_PERSIST_EN
    pulse_frame(1);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL persist_3frames got=%b want=000", rgb());
    end
    frame_start = 1'b1;
    strobe(8'h04, 8'h01);
    frame_start = 1'b0;
    cyc(1);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL persist_refresh_tie got=%b want=111", rgb());
    end
    pulse_frame(2);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL persist_tie_count0 got=%b want=111", rgb());
    end
    pulse_frame(1);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL persist_tie_expire got=%b want=000", rgb());
    end
`else
    pulse_frame(5);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL no_persist_held got=%b want=111", rgb());
    end
`endif
  endtask

  task automatic test_reset_mid();
    strobe(8'h01, 8'h06);
    set_el(31, 4);
    cyc(2);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL rmid_before got=%b want=111", rgb());
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL rmid_n1 got=%b want=000", rgb());
    end
    cyc(1);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL rmid_n2 got=%b want=000", rgb());
    end
    cyc(1);
    total++;
    if (rgb() !== 3'b000) begin
      bad++;
      $display("FAIL rmid_digit_cleared got=%b want=000", rgb());
    end
    set_el(1, 1);
    cyc(2);
    total++;
    if (rgb() !== 3'b111) begin
      bad++;
      $display("FAIL rmid_resume got=%b want=111", rgb());
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_led_keys_sep();
    test_latency();
    test_bounds();
    test_persist();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/virtual_tm1638_scanned_display.md
# virtual_tm1638_scanned_display

Parametrised successor to the virtual TM1638 graphics renderer. It accepts a dynamically multiplexed segment bus, where one digit is strobed at a time as on real LED-scanning hardware, and latches segments per digit. With persistence enabled, it blanks digits that stop being refreshed. It renders LEDs, keys, separator and seven-segment digits as a scaled grid through a registered pixel pipeline into the board's VGA colour path. It sits between the lab's display driver logic and the board's VGA timing generator.

## Interface
Parameters:
- w_digit, 8, number of digits
- w_led, 8, number of LEDs, ≤ w_digit
- w_keys, 8, number of keys, ≤ w_digit
- screen_width, 640; screen_height, 480, visible area in pixels
- w_x, $clog2(screen_width); w_y, $clog2(screen_height), coordinate widths
- scale_shift, 4, element size is 2^scale_shift pixels square
- offset_x, 16; offset_y, 16, pixel origin of the grid
- persist_frames, 3, frames a digit survives without refresh, 1..255

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- hgfedcba  in  8  segment data for the strobed digit(s)
- digit  in  w_digit  digit strobe; bit i selects digit i
- ledr  in  w_led  LED states
- keys  in  w_keys  key states
- display_on  in  1  when 0, the whole panel renders black
- frame_start  in  1  one-cycle pulse at the start of each frame
- x  in  w_x  current pixel x
- y  in  w_y  current pixel y
- red, green, blue  out  1 each  registered pixel colour

## Operation
- Segment latch: on each cycle where digit[i]=1, hex[i] ← hgfedcba. This is done for every set bit, so multi-bit strobes write all selected digits. digit=0 writes nothing.
- Grid: display columns dispx = 4·w_digit+1, rows 8.
  - Element coords: ex = (x−offset_x)>>scale_shift, ey = (y−offset_y)>>scale_shift.
  - A pixel is outside the grid if x<offset_x, y<offset_y, ex≥dispx or ey≥8. Outside pixels render black.
- Digit i occupies base column b=(w_digit−1−i)·4, so digit 0 is rightmost.
  - Row 0: ledr[i] at b+1..b+3 (i<w_led).
  - Row 1: separator, lit at columns 1..dispx−2.
  - Row 2: keys[i] at b+1..b+3 (i<w_keys).
  - Row 3: a at b+2.
  - Row 4: f at b+1, b at b+3.
  - Row 5: g at b+2.
  - Row 6: e at b+1, c at b+3.
  - Row 7: d at b+2, h at b+4.
  - All other elements are unlit.
- Colour of lit elements:
  - Row 0: red only.
  - Row 1: white.
  - Row 2: red+blue.
  - Rows 3–7: red+green+blue.
- display_on=0 forces black, without clearing any state.

## Timing
- Pixel pipeline latency is 2 cycles:
  - Stage 1 registers ex, ey and the in-grid flag.
  - Stage 2 registers red/green/blue.
  - x/y presented at cycle n appear on outputs at n+2.
- Segment data written at cycle n is visible in the stage-2 lookup from cycle n+1, so pixel output reflects it from n+2 at the earliest.
- Reset values: red=green=blue=0, pipeline registers 0, hex[i]=0 for all i, persistence counters saturated (all digits blank).
- rst asserted mid-frame clears everything within the same edge. Outputs are 0 on the cycle after rst and remain 0 until 2 cycles after rst deasserts.
- Simultaneous frame_start and digit[i]=1: the refresh wins, and digit i's counter is set to 0.

## Configuration
- VIRTUAL_TM1638_PERSIST_EN defined:
  - Each digit has an 8-bit age counter.
  - A write to the digit sets its counter to 0.
  - frame_start increments each counter, saturating at persist_frames.
  - A digit whose counter equals persist_frames renders rows 3–7 unlit; hex is kept.
- Not defined:
  - No counters are built.
  - Latched segments display indefinitely.
  - frame_start is ignored.
  - After reset, digits show hex=0, which is unlit.

## Test plan
- Reset, then scan x,y over the full screen → all outputs 0 for every pixel. With PERSIST_EN, also strobe digit=8'h01 with hgfedcba=8'h3F and scan → digit 0 draws "0" (rows 3–7 white at cols 29..31 pattern).
- digit=8'h81, hgfedcba=8'h06 → digits 0 and 7 both show "1". Element (ex=3, ey=4) is white; (ex=2, ey=3) is black.
- Drive x,y to element (ex=1, ey=0) with ledr[7]=1 → red=1, green=0, blue=0 exactly 2 cycles later. Drive the same element with ledr[7]=0 → outputs all 0 two cycles later.
- PERSIST_EN, persist_frames=3: refresh digit 2 once, then pulse frame_start ×2 → still lit. Third pulse → blank. Refresh again, on the same cycle as a frame_start → lit, counter 0.
- x=offset_x−1, and ex=dispx → black even though display_on=1 and all segments set. display_on=0 → whole screen black, and the state is retained after display_on returns to 1.
- Assert rst for 1 cycle mid-line → outputs 0 from the next cycle, and a previously latched digit reads back blank/0.
